// File: rtl/pe_ctx_sequencer.sv
// pe_ctx_sequencer: context sequencer for a row of 4-bit ALU PEs.
// Holds one control word per PE per context slot. It issues contexts
// 0..last_ctx one per cycle, drives PE enables and control words, and
// follows each issued context through the PE pipeline to produce result_valid.
// Optional feature macro: PE_CTX_SEQUENCER_LOOP_EN. When it is defined, the
// run repeats iters+1 times. When it is undefined, iters is ignored.
// The port named reset is active-low and asynchronous.
module pe_ctx_sequencer #(
    parameter int NUM_PE  = 4,
    parameter int NUM_CTX = 8,
    parameter int CTRL_W  = 8,
    parameter int PE_LAT  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(NUM_CTX)-1:0] cfg_ctx,
    input  logic [$clog2(NUM_PE)-1:0]  cfg_pe,
    input  logic [CTRL_W-1:0]          cfg_data,
    input  logic                       start,
    input  logic [$clog2(NUM_CTX)-1:0] last_ctx,
    input  logic [3:0]                 iters,
    input  logic                       stall,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_PE-1:0]          pe_en,
    output logic [NUM_PE*CTRL_W-1:0]   pe_ctrl,
    output logic                       result_valid,
    output logic [$clog2(NUM_CTX)-1:0] result_ctx
);
    localparam int CTX_W = $clog2(NUM_CTX);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                   state;
    logic [CTRL_W-1:0]        mem [NUM_CTX][NUM_PE];
    logic [CTX_W-1:0]         ctx_ptr;
    logic [CTX_W-1:0]         last_q;
    logic [NUM_PE*CTRL_W-1:0] ctrl_q;
    logic [PE_LAT-1:0]        dl_valid;
    logic [CTX_W-1:0]         dl_ctx [PE_LAT];

    logic                     active;
    logic                     advance;
    logic                     write_fire;
    logic                     last_in_iter;
    logic                     final_issue;
    logic                     drain_last;
    logic [CTX_W-1:0]         next_ptr;
    logic [CTX_W-1:0]         fetch_idx;
    logic [NUM_PE*CTRL_W-1:0] fetch_slot;

`ifdef PE_CTX_SEQUENCER_LOOP_EN
    logic [3:0]               iter_cnt;
    logic [3:0]               iters_q;
`else
    // iters has no effect in this build. This sink keeps the port legal.
    logic                     iters_unused;
    assign iters_unused = ^iters;
`endif

    assign active     = (state == ISSUE) || (state == DRAIN);
    assign advance    = active && !stall;
    assign cfg_ready  = ((state == IDLE) && !start) || (state == DONE);
    assign write_fire = cfg_valid && cfg_ready;

    assign last_in_iter = (ctx_ptr == last_q);
`ifdef PE_CTX_SEQUENCER_LOOP_EN
    assign final_issue = last_in_iter && (iter_cnt == iters_q);
`else
    assign final_issue = last_in_iter;
`endif

    assign busy         = active;
    assign done         = (state == DONE);
    assign pe_en        = {NUM_PE{(state == ISSUE) && !stall}};
    assign pe_ctrl      = ctrl_q;
    assign result_valid = dl_valid[PE_LAT-1] && advance;
    assign result_ctx   = dl_ctx[PE_LAT-1];

    // Next context to issue, its control slot, and the drain-complete test.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        next_ptr   = last_in_iter ? '0 : ctx_ptr + 1'b1;
        fetch_idx  = (state == ISSUE) ? next_ptr : '0;
        fetch_slot = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            fetch_slot[p*CTRL_W +: CTRL_W] = mem[fetch_idx][p];
        end
        drain_last = dl_valid[PE_LAT-1];
        for (int i = 0; i < PE_LAT - 1; i++) begin
            if (dl_valid[i]) begin
                drain_last = 1'b0;
            end
        end
    end

    // Context memory. Host writes land here only while the sequencer is idle or done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the memory must read as zero after reset, so it is a flop array with a reset rather than a RAM.
            for (int c = 0; c < NUM_CTX; c++) begin
                for (int p = 0; p < NUM_PE; p++) begin
                    mem[c][p] <= '0;
                end
            end
        end else if (write_fire) begin
            mem[cfg_ctx][cfg_pe] <= cfg_data;
        end
    end

    // Sequencer FSM. It owns the context pointer, the latched run bounds and the control word register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: state uses non-blocking assignments, so every branch reads values from before the edge.
            state   <= IDLE;
            ctx_ptr <= '0;
            last_q  <= '0;
            ctrl_q  <= '0;
`ifdef PE_CTX_SEQUENCER_LOOP_EN
            iter_cnt <= '0;
            iters_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_q  <= last_ctx;
                        ctx_ptr <= '0;
                        ctrl_q  <= fetch_slot;
                        state   <= ISSUE;
`ifdef PE_CTX_SEQUENCER_LOOP_EN
                        iters_q  <= iters;
                        iter_cnt <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        ctx_ptr <= next_ptr;
                        if (final_issue) begin
                            state <= DRAIN;
                        end else begin
                            ctrl_q <= fetch_slot;
`ifdef PE_CTX_SEQUENCER_LOOP_EN
                            if (last_in_iter) begin
                                iter_cnt <= iter_cnt + 4'd1;
                            end
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (!stall && drain_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Valid delay line. It mirrors the PE pipeline and advances only when the array is not stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dl_valid <= '0;
            for (int i = 0; i < PE_LAT; i++) begin
                dl_ctx[i] <= '0;
            end
        end else if (advance) begin
            dl_valid[0] <= (state == ISSUE);
            dl_ctx[0]   <= ctx_ptr;
            for (int i = 1; i < PE_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_ctx[i]   <= dl_ctx[i-1];
            end
        end
    end

endmodule
